// File: rtl/riskbes_pkg.sv
// -----------------------------------------------------------------------------
// riskbes_pkg
// Shared definitions for the fetch front end: data widths, the instruction
// word address width used by instr_cache, the canonical NOP encoding, the
// default reset PC and the prefetch FIFO entry layout.
// -----------------------------------------------------------------------------
package riskbes_pkg;

   localparam int unsigned XLEN             = 32;
   localparam int unsigned IADDR_W          = 29;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // One prefetched instruction together with the PC it was fetched from.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous prefetch FIFO holding fetch_entry_t records.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   push_i        write wdata_i at the tail (a push into a full FIFO is only
//                 legal together with pop_i)
//   pop_i         drop the head entry
//   flush_i       discard every entry; overrides push_i and pop_i
//   wdata_i       entry to write
//   head_o        head entry, all-zero while the FIFO is empty
//   count_o       number of valid entries (0..DEPTH)
// -----------------------------------------------------------------------------
module fetch_fifo
   import riskbes_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               push_i,
   input  logic               pop_i,
   input  logic               flush_i,
   input  fetch_entry_t       wdata_i,
   output fetch_entry_t       head_o,
   output logic [CNT_W-1:0]   count_o
);

   fetch_entry_t            mem_q [DEPTH];
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]        count_q,  count_d;

   // Pointers wrap explicitly so that non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   // Next-state for pointers and occupancy; flush wins over push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = {PTR_W{1'b0}};
         rd_ptr_d = {PTR_W{1'b0}};
         count_d  = {CNT_W{1'b0}};
      end else begin
         if (push_i) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_i) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents need no reset because the head is masked when empty.
   // When full, push+pop writes the slot being vacated by the head this cycle.
   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign head_o  = (count_q != {CNT_W{1'b0}}) ? mem_q[rd_ptr_q] : fetch_entry_t'({64{1'b0}});
   assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch: owns the PC, reads instr_cache combinationally, buffers
// {instr, pc} in a prefetch FIFO and hands entries to decode with valid/ready.
// A redirect from execute flushes the FIFO and restarts fetch at the target.
// Optional build macro FETCH_PERF_EN adds fetch/flush event counters.
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   fetch_en_i         allow new fetches (buffered entries still drain)
//   cache_addr_o       word address to instr_cache (pc_q[30:2])
//   cache_data_i       instruction word for cache_addr_o, same cycle
//   redirect_i         one-cycle redirect request
//   redirect_pc_i      redirect target, low two bits ignored
//   instr_valid_o      head valid for decode (suppressed during redirect)
//   instr_ready_i      decode accepts the head
//   instr_o            head instruction (0 when empty)
//   instr_pc_o         head PC (0 when empty)
//   fetch_count_o      [FETCH_PERF_EN] instructions handed to decode
//   flush_count_o      [FETCH_PERF_EN] redirects that discarded entries
// -----------------------------------------------------------------------------
module fetch_stage
   import riskbes_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                fetch_en_i,
   output logic [IADDR_W-1:0]  cache_addr_o,
   input  logic [XLEN-1:0]     cache_data_i,
   input  logic                redirect_i,
   input  logic [XLEN-1:0]     redirect_pc_i,
`ifdef FETCH_PERF_EN
   output logic [31:0]         fetch_count_o,
   output logic [31:0]         flush_count_o,
`endif
   output logic                instr_valid_o,
   input  logic                instr_ready_i,
   output logic [XLEN-1:0]     instr_o,
   output logic [XLEN-1:0]     instr_pc_o
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [XLEN-1:0]   pc_q, pc_d;
   logic [CNT_W-1:0]  count_s;
   logic              pop_s;
   logic              push_s;
   fetch_entry_t      head_s;
   fetch_entry_t      wdata_s;

   // Valid is masked during a redirect so decode can never take a stale head.
   assign instr_valid_o = (count_s != {CNT_W{1'b0}}) & ~redirect_i;
   assign pop_s         = instr_valid_o & instr_ready_i;
   // A full FIFO can still accept when the head leaves in the same cycle.
   assign push_s        = fetch_en_i & ~redirect_i &
                          ((count_s < CNT_W'(FIFO_DEPTH)) | pop_s);

   assign cache_addr_o  = pc_q[30:2];
   assign wdata_s.instr = cache_data_i;
   assign wdata_s.pc    = pc_q;
   assign instr_o       = head_s.instr;
   assign instr_pc_o    = head_s.pc;

   // PC next-state: redirect first, then sequential advance on a push.
   always_comb begin
      pc_d = pc_q;
      if (redirect_i) begin
         pc_d = redirect_pc_i & 32'hFFFF_FFFC;
      end else if (push_s) begin
         pc_d = pc_q + 32'd4;
      end else begin
         pc_d = pc_q;
      end
   end

   // Program counter register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   fetch_fifo #(
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .flush_i (redirect_i),
      .wdata_i (wdata_s),
      .head_o  (head_s),
      .count_o (count_s)
   );

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_count_q;
   logic [31:0] flush_count_q;

   // Event counters; both wrap naturally at 2^32.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fetch_count_q <= 32'd0;
         flush_count_q <= 32'd0;
      end else begin
         if (pop_s) begin
            fetch_count_q <= fetch_count_q + 32'd1;
         end
         if (redirect_i && (count_s != {CNT_W{1'b0}})) begin
            flush_count_q <= flush_count_q + 32'd1;
         end
      end
   end

   assign fetch_count_o = fetch_count_q;
   assign flush_count_o = flush_count_q;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage directly upstream of decode and the consumer of instr_cache.
- Holds the program counter and drives the cache's 29-bit word address.
- Captures each combinational read into a small prefetch FIFO and presents {instr, pc} to decode over a valid/ready handshake.
- Accepts redirects (taken branch/jump) from execute, which flush all buffered instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- FIFO_DEPTH, 2, prefetch entries; legal range 2..8.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- fetch_en_i  input  1  fetch enable; 0 blocks new FIFO pushes, PC holds.
- cache_addr_o  output  29  word address to instr_cache; equals pc_q[30:2].
- cache_data_i  input  32  instruction word from instr_cache, valid in the same cycle as cache_addr_o.
- redirect_i  input  1  one-cycle redirect request from execute.
- redirect_pc_i  input  32  redirect target; bits [1:0] ignored (treated as 0).
- instr_valid_o  output  1  FIFO head valid for decode.
- instr_ready_i  input  1  decode accepts the head this cycle.
- instr_o  output  32  FIFO head instruction word.
- instr_pc_o  output  32  FIFO head PC.

Behaviour:
- Reset (async assert, sync release): pc_q=RESET_PC, FIFO count=0, rd/wr pointers=0, instr_valid_o=0, instr_o=0, instr_pc_o=0, cache_addr_o=RESET_PC[30:2].
- cache_addr_o = pc_q[30:2], combinational from the register; bit 31 of the PC is dropped.
- pop = instr_valid_o & instr_ready_i.
- push = fetch_en_i & !redirect_i & (count<FIFO_DEPTH | pop).
  - A full FIFO with a simultaneous pop still pushes.
- On push: write entry {cache_data_i, pc_q}; pc_q <= pc_q+4. The add wraps modulo 2^32: 32'hFFFF_FFFC -> 0.
- No push: pc_q holds.
- instr_valid_o = (count!=0) & !redirect_i.
  - Gated so decode never accepts a younger instruction in a redirect cycle.
- instr_o / instr_pc_o show the head entry. They are 0 when the FIFO is empty. They are not gated by redirect_i.
- Redirect has priority over push and pop:
  - count <= 0 and pointers reset.
  - pc_q <= {redirect_pc_i[31:2],2'b00}.
  - The head is not consumed.
- Latency:
  - First instruction valid 1 cycle after reset release, if fetch_en_i=1.
  - Redirect in cycle N: target fetched in N+1, instr_valid_o=1 in N+2.
  - Throughput is 1 instruction/cycle sustained while instr_ready_i=1.
- Back-to-back redirects: each one wins; only the last target is fetched.
- fetch_en_i deassert: buffered entries still drain to decode; no new fetches.
- count never exceeds FIFO_DEPTH and never underflows. Pops with count=0 are impossible because valid=0.
- Reset mid-operation: the FIFO is discarded immediately and outputs go to their reset values asynchronously.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds output ports fetch_count_o[31:0] and flush_count_o[31:0].
  - fetch_count_o increments on each pop.
  - flush_count_o increments on each redirect cycle where count!=0 (instructions discarded).
  - Both reset to 0 and wrap at 2^32.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package riskbes_pkg:
  - XLEN=32.
  - IADDR_W=29.
  - NOP_INSTR=32'h0000_0013.
  - default RESET_PC.
  - fetch entry struct {instr[31:0], pc[31:0]}.
- One sub-module: fetch_fifo.
  - Parameterised synchronous FIFO with push/pop/flush, count, and head read.
  - Async active-high reset on clk_i/rst_i.
- fetch_stage holds the PC register, the push/pop/redirect logic and the optional counters.

Test Plan:
- Reset release with fetch_en_i=1, instr_ready_i=1, cache words 0..2 = 32'h00000093, 32'h10000113, 32'h00a00193:
  - instr_valid_o rises 1 cycle later.
  - instr_pc_o sequence 0,4,8 with matching instr_o.
  - cache_addr_o sequence 0,1,2.
- Backpressure: hold instr_ready_i=0 for 5 cycles:
  - FIFO fills to 2.
  - cache_addr_o stalls at 2.
  - head stays pc=0.
  - On release: pcs 0,4,8 delivered with no gaps or duplicates.
- Redirect with redirect_pc_i=32'h0000_0063 while the FIFO is full:
  - instr_valid_o=0 that cycle and the next.
  - cache_addr_o=24 next cycle.
  - next delivered instr_pc_o=32'h60.
  - the old head is never accepted.
- Redirect asserted together with instr_ready_i=1 and a full FIFO: no pop counted, count=0 afterwards; with FETCH_PERF_EN, flush_count_o increments by 1.
- PC wrap: redirect to 32'hFFFF_FFFC:
  - delivered pcs FFFF_FFFC then 0000_0000.
  - cache_addr_o 29'h1FFF_FFFF then 0.
- Assert rst_i asynchronously mid-stream (count=2): instr_valid_o drops without a clock edge; after release, fetch restarts at RESET_PC.
